// File: rtl/if_stage_if.sv
// Instruction-memory port between the fetch stage (master) and the instruction ROM (slave).
// The ROM read is combinational: imem_rdata follows imem_addr within the same cycle.
interface if_stage_if #(
    parameter int IMEM_AW = 10
);
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;

    modport master (output imem_addr, input  imem_rdata);
    modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/if_stage.sv
// Fetch stage: PC register, instruction-ROM addressing and the IF/ID pipeline register.
// Redirect priority is taken branch > stall > jump > sequential fetch.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    if_stage_if.master  imem,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    // Flushed slot carries sll $0,$0,0 so the ID splitter sees a harmless nop.
    localparam if_id_t IF_ID_BUBBLE = '{instr: 32'h0000_0000, pc_plus4: 32'h0, valid: 1'b0};

    if_id_t      if_id_q;
    logic [31:0] pc_plus4;

    assign pc_plus4       = pc + 32'd4;
    assign imem.imem_addr = pc[IMEM_AW+1:2];

    assign if_id_instr    = if_id_q.instr;
    assign if_id_pc_plus4 = if_id_q.pc_plus4;
    assign if_id_valid    = if_id_q.valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            if_id_q     <= IF_ID_BUBBLE;
            fetch_count <= 32'd0;
        end else if (branch_taken) begin
            // Oldest redirect: wins over a simultaneous stall or jump.
            pc      <= {branch_target[31:2], 2'b00};
            if_id_q <= IF_ID_BUBBLE;
        end else if (stall) begin
            pc      <= pc;
            if_id_q <= if_id_q;
        end else if (jump) begin
            pc      <= {jump_target[31:2], 2'b00};
            if_id_q <= IF_ID_BUBBLE;
        end else begin
            pc          <= pc_plus4;
            if_id_q     <= '{instr: imem.imem_rdata, pc_plus4: pc_plus4, valid: 1'b1};
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; the ROM returns 32'h1000_0000 + word address.
module tb_if_stage;

    localparam int IMEM_AW = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] pc, if_id_instr, if_id_pc_plus4, fetch_count;
    logic        if_id_valid;

    int n_pass = 0;
    int n_total = 0;

    if_stage_if #(.IMEM_AW(IMEM_AW)) bus ();

    assign bus.imem_rdata = 32'h1000_0000 + 32'(bus.imem_addr);

    if_stage #(.RESET_PC(32'h0), .IMEM_AW(IMEM_AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (bus.master),
        .stall          (stall),
        .jump           (jump),
        .jump_target    (jump_target),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .pc             (pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic [31:0] e_pc4, input logic e_vld, input logic [31:0] e_cnt);
        chk({tag, ".pc"},    pc,              e_pc);
        chk({tag, ".instr"}, if_id_instr,     e_instr);
        chk({tag, ".pc4"},   if_id_pc_plus4,  e_pc4);
        chk({tag, ".valid"}, 32'(if_id_valid), 32'(e_vld));
        chk({tag, ".count"}, fetch_count,     e_cnt);
    endtask

    initial begin
        #2;
        chk_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_reset.addr", 32'(bus.imem_addr), 32'h0);
        chk("post_reset.valid", 32'(if_id_valid), 32'h0);

        // Free run: word at pc 0 lands in IF/ID one edge later.
        step(); chk_state("run1", 32'h4, 32'h1000_0000, 32'h4, 1'b1, 32'd1);
        step(); chk_state("run2", 32'h8, 32'h1000_0001, 32'h8, 1'b1, 32'd2);

        stall = 1'b1;
        step(); chk_state("stall1", 32'h8, 32'h1000_0001, 32'h8, 1'b1, 32'd2);
        step(); chk_state("stall2", 32'h8, 32'h1000_0001, 32'h8, 1'b1, 32'd2);
        stall = 1'b0;
        step(); chk_state("resume", 32'hC, 32'h1000_0002, 32'hC, 1'b1, 32'd3);
        step(); chk_state("run4", 32'h10, 32'h1000_0003, 32'h10, 1'b1, 32'd4);
        step(); chk_state("run5", 32'h14, 32'h1000_0004, 32'h14, 1'b1, 32'd5);

        branch_taken = 1'b1; branch_target = 32'h40;
        step(); chk_state("branch", 32'h40, 32'h0, 32'h0, 1'b0, 32'd5);
        branch_taken = 1'b0;
        step(); chk_state("br_fetch", 32'h44, 32'h1000_0010, 32'h44, 1'b1, 32'd6);

        jump = 1'b1; jump_target = 32'h0000_0123;
        step(); chk_state("jump", 32'h120, 32'h0, 32'h0, 1'b0, 32'd6);
        jump_target = 32'h0000_0200; stall = 1'b1;
        step(); chk_state("jump_stall", 32'h120, 32'h0, 32'h0, 1'b0, 32'd6);
        jump = 1'b0; stall = 1'b0;
        step(); chk_state("jmp_fetch", 32'h124, 32'h1000_0048, 32'h124, 1'b1, 32'd7);

        branch_taken = 1'b1; branch_target = 32'h0000_002F;
        jump = 1'b1; jump_target = 32'h80; stall = 1'b1;
        step(); chk_state("all3", 32'h2C, 32'h0, 32'h0, 1'b0, 32'd7);
        branch_taken = 1'b0; jump = 1'b0; stall = 1'b0;
        step(); chk_state("run_30", 32'h30, 32'h1000_000B, 32'h30, 1'b1, 32'd8);

        // Asynchronous reset between edges.
        #3 rst_n = 1'b0;
        #1;
        chk_state("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        chk("async_rst.addr", 32'(bus.imem_addr), 32'h0);
        #2 rst_n = 1'b1;
        step(); chk_state("rst_run", 32'h4, 32'h1000_0000, 32'h4, 1'b1, 32'd1);

        // A jump pulse that misses the edge must have no effect.
        #2 jump = 1'b1; jump_target = 32'h300;
        #2 jump = 1'b0;
        step(); chk_state("glitch", 32'h8, 32'h1000_0001, 32'h8, 1'b1, 32'd2);

        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        step(); chk("wrap.pc", pc, 32'hFFFF_FFFC);
        chk("wrap.addr", 32'(bus.imem_addr), 32'h3FF);
        branch_taken = 1'b0;
        step(); chk_state("wrap", 32'h0, 32'h1000_03FF, 32'h0, 1'b1, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
